// File: rtl/apb_timer_cfg_master.sv
`default_nettype none
// =============================================================================
// apb_timer_cfg_master: valid/ready command stream to APB3 initiator (timx_p* bus).
// Optional stall watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
module apb_timer_cfg_master #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              apb_clk,
  input  logic              apb_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              timx_psel,
  output logic              timx_penable,
  output logic              timx_pwrite,
  output logic [ADDR_W-1:0] timx_paddr,
  output logic [DATA_W-1:0] timx_pwdata,
  input  logic [DATA_W-1:0] timx_prdata,
  input  logic              timx_pready,
  input  logic              timx_pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  // Abort fires at the edge where the wait count would reach the limit.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign rsp_timeout        = 1'b0;
`endif

  assign cmd_ready    = (state_q == ST_IDLE);
  assign timx_psel    = psel_q;
  assign timx_penable = penable_q;
  assign timx_pwrite  = pwrite_q;
  assign timx_paddr   = paddr_q;
  assign timx_pwdata  = pwdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (timx_pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : timx_prdata;
          rsp_err_d   = timx_pslverr;
          state_d     = ST_IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_cfg_master.sv
`default_nettype none
// =============================================================================
// tb_apb_timer_cfg_master: scoreboard bench with an APB slave model and a
// transaction-level response predictor. Revision: 1.0
// =============================================================================
module tb_apb_timer_cfg_master;

  localparam int TMO = 4;

  logic        apb_clk;
  logic        apb_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        timx_psel;
  logic        timx_penable;
  logic        timx_pwrite;
  logic [15:0] timx_paddr;
  logic [31:0] timx_pwdata;
  logic [31:0] timx_prdata;
  logic        timx_pready;
  logic        timx_pslverr;

  apb_timer_cfg_master #(
    .ADDR_W(16),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .apb_clk(apb_clk),
    .apb_rst_n(apb_rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .timx_psel(timx_psel),
    .timx_penable(timx_penable),
    .timx_pwrite(timx_pwrite),
    .timx_paddr(timx_paddr),
    .timx_pwdata(timx_pwdata),
    .timx_prdata(timx_prdata),
    .timx_pready(timx_pready),
    .timx_pslverr(timx_pslverr)
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] srdata;
    logic        serr;
    int          waits;
    int          acc_k;
    int          done_k;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } txn_t;

  txn_t exp_q[$];
  txn_t slv_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_done_k = 0;

  initial apb_clk = 1'b0;
  always #5 apb_clk = ~apb_clk;

  initial forever begin
    @(posedge apb_clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cyc %0d)", name, cyc);
  endtask

  // Response predicted from the slave's behaviour: wait count, data and error.
  function automatic txn_t predict(input txn_t t);
    txn_t r;
    r           = t;
    r.exp_rdata = t.wr ? 32'd0 : t.srdata;
    r.exp_err   = t.serr;
    r.exp_to    = 1'b0;
    r.done_k    = t.acc_k + 3 + t.waits;
`ifdef APB_MASTER_TIMEOUT_EN
    if (t.waits >= TMO) begin
      r.exp_rdata = 32'd0;
      r.exp_err   = 1'b1;
      r.exp_to    = 1'b1;
      r.done_k    = t.acc_k + 2 + TMO;
    end
`endif
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [31:0] srd, input logic serr, input int waits, input bit keep);
    txn_t t;
    int   guard;
    bit   held;
    held      = (cmd_valid == 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    guard     = 0;
    while (!cmd_ready && guard < 300) begin
      @(negedge apb_clk);
      guard++;
    end
    if (!cmd_ready) begin
      note_fail("accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    t.wr     = wr;
    t.addr   = addr;
    t.wdata  = wd;
    t.srdata = srd;
    t.serr   = serr;
    t.waits  = waits;
    t.acc_k  = cyc;
    t.done_k = 0;
    t.exp_rdata = '0;
    t.exp_err   = 1'b0;
    t.exp_to    = 1'b0;
    t = predict(t);
    if (held) check("b2b_accept_cycle", 64'(cyc), 64'(last_done_k));
    last_done_k = t.done_k;
    exp_q.push_back(t);
    slv_q.push_back(t);
    @(posedge apb_clk);
    @(negedge apb_clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  // APB slave model
  initial begin
    txn_t cur;
    txn_t pk;
    bit   active;
    int   acc_n;
    active       = 1'b0;
    acc_n        = 0;
    cur          = '0;
    timx_pready  = 1'b0;
    timx_prdata  = '0;
    timx_pslverr = 1'b0;
    forever begin
      @(negedge apb_clk);
      timx_pready  = 1'($urandom);
      timx_prdata  = $urandom;
      timx_pslverr = 1'($urandom);
      if (timx_psel && !timx_penable) begin
        active = 1'b0;
        if (slv_q.size() == 0) note_fail("unexpected_setup");
        else begin
          pk = slv_q[0];
          check("setup_cycle", 64'(cyc), 64'(pk.acc_k + 1));
          check("setup_paddr", 64'(timx_paddr), 64'(pk.addr));
          check("setup_pwrite", 64'(timx_pwrite), 64'(pk.wr));
          check("setup_pwdata", 64'(timx_pwdata), 64'(pk.wdata));
        end
      end else if (timx_psel && timx_penable) begin
        if (!active) begin
          if (slv_q.size() == 0) note_fail("unexpected_access");
          else begin
            cur    = slv_q.pop_front();
            active = 1'b1;
            acc_n  = 0;
            check("access_cycle", 64'(cyc), 64'(cur.acc_k + 2));
          end
        end
        if (active) begin
          acc_n++;
          check("access_paddr", 64'(timx_paddr), 64'(cur.addr));
          check("access_pwrite", 64'(timx_pwrite), 64'(cur.wr));
          check("access_pwdata", 64'(timx_pwdata), 64'(cur.wdata));
          timx_pready = (acc_n > cur.waits);
          if (timx_pready) begin
            timx_prdata  = cur.srdata;
            timx_pslverr = cur.serr;
          end
        end else timx_pready = 1'b1;
      end else active = 1'b0;
    end
  end

  // Response monitor
  initial begin
    txn_t        e;
    logic [31:0] last_rdata;
    logic        last_err;
    last_rdata = '0;
    last_err   = 1'b0;
    forever begin
      @(negedge apb_clk);
      if (!apb_rst_n) begin
        last_rdata = '0;
        last_err   = 1'b0;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) note_fail("unexpected_rsp_valid");
        else begin
          e = exp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(e.done_k));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.exp_rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.exp_err));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.exp_to));
          check("psel_low_at_rsp", 64'(timx_psel), 64'd0);
        end
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end else begin
        check("rsp_rdata_hold", 64'(rsp_rdata), 64'(last_rdata));
        check("rsp_err_hold", 64'(rsp_err), 64'(last_err));
      end
    end
  end

  initial begin
    int guard;
    bit keep;
    apb_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    @(negedge apb_clk);
    check("rst_psel", 64'(timx_psel), 64'd0);
    check("rst_penable", 64'(timx_penable), 64'd0);
    check("rst_pwrite", 64'(timx_pwrite), 64'd0);
    check("rst_paddr", 64'(timx_paddr), 64'd0);
    check("rst_pwdata", 64'(timx_pwdata), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    #2 apb_rst_n = 1'b1;
    @(negedge apb_clk);

    // Zero-wait write, then read with two wait states
    send(1'b1, 16'h002C, 32'h0000_0036, 32'hAAAA_5555, 1'b0, 0, 1'b0);
    repeat (4) @(negedge apb_clk);
    send(1'b0, 16'h0010, 32'h0, 32'h0000_0041, 1'b0, 2, 1'b0);
    repeat (6) @(negedge apb_clk);

    // Back-to-back held sequence
    send(1'b1, 16'h0018, 32'h0000_0100, 32'h0, 1'b0, 0, 1'b1);
    send(1'b1, 16'h0020, 32'h0000_0000, 32'h0, 1'b0, 0, 1'b1);
    send(1'b1, 16'h0008, 32'h0000_0066, 32'h0, 1'b0, 0, 1'b1);
    send(1'b1, 16'h000C, 32'h0000_0040, 32'h0, 1'b0, 0, 1'b1);
    send(1'b1, 16'h0000, 32'h0000_0001, 32'h0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge apb_clk);

    // Slave error then clean read
    send(1'b1, 16'h0004, 32'h1234_0000, 32'h0, 1'b1, 1, 1'b0);
    send(1'b0, 16'h0014, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
    repeat (6) @(negedge apb_clk);

    // Reset while ACCESS is stalled
    send(1'b1, 16'h0030, 32'hDEAD_BEEF, 32'h0, 1'b0, 1000, 1'b0);
    guard = 0;
    while (!(timx_psel && timx_penable) && guard < 20) begin
      @(negedge apb_clk);
      guard++;
    end
    check("reached_access", 64'(timx_psel && timx_penable), 64'd1);
    @(negedge apb_clk);
    #2 apb_rst_n = 1'b0;
    #1;
    check("async_rst_psel", 64'(timx_psel), 64'd0);
    check("async_rst_penable", 64'(timx_penable), 64'd0);
    exp_q.delete();
    slv_q.delete();
    repeat (2) @(negedge apb_clk);
    check("rst2_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst2_paddr", 64'(timx_paddr), 64'd0);
    #2 apb_rst_n = 1'b1;
    @(negedge apb_clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    send(1'b1, 16'h0034, 32'h1234_5678, 32'h0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge apb_clk);

`ifdef APB_MASTER_TIMEOUT_EN
    send(1'b0, 16'h0024, 32'h0, 32'h5A5A_5A5A, 1'b0, 1000, 1'b0);
    repeat (TMO + 4) @(negedge apb_clk);
`endif
    // pready rises on the TMO-th ACCESS cycle
    send(1'b0, 16'h0028, 32'h0, 32'h0000_00C3, 1'b0, TMO - 1, 1'b0);
    repeat (TMO + 4) @(negedge apb_clk);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
`ifdef APB_MASTER_TIMEOUT_EN
      guard = int'($urandom_range(0, 6));
`else
      guard = int'($urandom_range(0, 3));
`endif
      keep = (i < 59) && ($urandom_range(0, 1) == 1);
      send(1'($urandom), 16'($urandom) & 16'hFFFC, $urandom, $urandom,
           ($urandom_range(0, 4) == 0), guard, keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge apb_clk);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge apb_clk);
      guard++;
    end
    check("drain_rsp_queue", 64'(exp_q.size()), 64'd0);
    check("drain_slave_queue", 64'(slv_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
